// File: rtl/shift_left_seq.sv
// -----------------------------------------------------------------------------
// shift_left_seq
//
// Sequencer that loads a parallel word into an external WIDTH-bit left shift
// register (shift_register_left) one bit per cycle, MSB first, then reads the
// register back and reports whether it holds the requested word.
//
// Ports
//   clk        rising-edge clock, shared with the shift register
//   rst_n      asynchronous active-low reset
//   start      load request, only honoured while ready=1
//   word       parallel word, captured on the accepting edge
//   abort      cancels a load in progress (only looked at while shifting)
//   ready      high while idle and able to accept start
//   sr_enable  shift-register enable (high for exactly WIDTH cycles per load)
//   sr_din     shift-register serial input, 0 whenever sr_enable=0
//   sr_q       shift-register parallel output
//   data_out   last read-back value of sr_q, held until the next completion
//   done       one-cycle pulse when a load completes
//   aborted    one-cycle pulse after an abort
//   mismatch   sticky flag: last read-back differed from the captured word;
//              cleared when the next start is accepted
//
// All outputs are flops. Their next values are decoded from the next state
// (and next count / captured word), so they behave as Moore decodes of the
// current state while having no combinational path from start or abort.
// -----------------------------------------------------------------------------
module shift_left_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic             abort,
    output logic             ready,
    output logic             sr_enable,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             aborted,
    output logic             mismatch
);

    // Counter just wide enough to hold 0..WIDTH-1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] word_q,      word_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic             mismatch_q,  mismatch_d;

    logic             ready_q,     ready_d;
    logic             sr_enable_q, sr_enable_d;
    logic             sr_din_q,    sr_din_d;
    logic             done_q,      done_d;
    logic             aborted_q,   aborted_d;

    // Bit-reversed copy of the word about to be held, so that indexing it
    // with the shift count yields the MSB first: msb_first[cnt] = word[W-1-cnt].
    logic [WIDTH-1:0] msb_first;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign msb_first[gi] = word_d[WIDTH-1-gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        mismatch_d = mismatch_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d     = word;
                    cnt_d      = '0;
                    mismatch_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // The register shifts on this edge regardless of abort,
                // because sr_enable is already high in this cycle.
                cnt_d = cnt_q + 1'b1;
                if (abort) begin
                    state_d = S_ABORT;
                end else if (cnt_q == LAST) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // Last shift edge was one full cycle ago, so sr_q is settled.
                data_out_d = sr_q;
                mismatch_d = (sr_q != word_q);
                state_d    = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ABORT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode of the next state, registered alongside the state.
    // -------------------------------------------------------------------------
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        sr_enable_d = (state_d == S_SHIFT);
        sr_din_d    = sr_enable_d & msb_first[cnt_d];
        done_d      = (state_d == S_DONE);
        aborted_d   = (state_d == S_ABORT);
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset values of the output flops equal the
    // IDLE decode, so ready is high and sr_enable drops as soon as rst_n falls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            data_out_q  <= '0;
            mismatch_q  <= 1'b0;
            ready_q     <= 1'b1;
            sr_enable_q <= 1'b0;
            sr_din_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            mismatch_q  <= mismatch_d;
            ready_q     <= ready_d;
            sr_enable_q <= sr_enable_d;
            sr_din_q    <= sr_din_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign ready     = ready_q;
    assign sr_enable = sr_enable_q;
    assign sr_din    = sr_din_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_left_seq
//
// Drives shift_left_seq against a behavioural 4-bit left shift register.
// Stimulus pushes one expected completion (done or aborted) per load into a
// scoreboard queue; a negedge monitor pops an entry whenever done or aborted
// pulses and compares data_out, mismatch, the number and order of serial bits,
// and the cycle at which the pulse appeared.
// -----------------------------------------------------------------------------
module tb_shift_left_seq;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic         abort    = 1'b0;
    logic [W-1:0] word     = '0;
    logic         force_zero = 1'b0;
    logic [W-1:0] sr_reg   = '0;

    logic         ready, sr_enable, sr_din, done, aborted, mismatch;
    logic [W-1:0] data_out;
    wire  [W-1:0] sr_q = force_zero ? '0 : sr_reg;

    shift_left_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .word     (word),
        .abort    (abort),
        .ready    (ready),
        .sr_enable(sr_enable),
        .sr_din   (sr_din),
        .sr_q     (sr_q),
        .data_out (data_out),
        .done     (done),
        .aborted  (aborted),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Behavioural shift_register_left (own reset never asserted here).
    always @(posedge clk) if (sr_enable) sr_reg <= {sr_reg[W-2:0], sr_din};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit           is_abort;
        logic [W-1:0] dout;
        bit           mm;
        int           nsh;
        logic [7:0]   bits;
        int           at_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input bit ab, input logic [W-1:0] d, input bit m,
                            input int n, input logic [7:0] b, input int c);
        exp_t e;
        e.is_abort = ab; e.dout = d; e.mm = m; e.nsh = n; e.bits = b; e.at_cyc = c;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------ monitor
    int         nsh  = 0;
    logic [7:0] bits = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            nsh  = 0;
            bits = '0;
        end else begin
            if (!sr_enable && sr_din) chk("sr_din_when_disabled", 32'(sr_din), 0);
            if (sr_enable) begin
                nsh++;
                bits = {bits[6:0], sr_din};
            end
            if (done || aborted) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b aborted=%0b required no pulse (cycle %0d)",
                             done, aborted, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("txn %s at cycle %0d: data_out=%b mismatch=%0b shifts=%0d",
                             e.is_abort ? "abort" : "load ", cyc, data_out, mismatch, nsh);
                    chk("aborted_pulse", 32'(aborted), 32'(e.is_abort));
                    chk("done_pulse",    32'(done),    32'(!e.is_abort));
                    chk("data_out",      32'(data_out), 32'(e.dout));
                    chk("mismatch",      32'(mismatch), 32'(e.mm));
                    chk("shift_count",   32'(nsh),      32'(e.nsh));
                    chk("serial_bits",   32'(bits),     32'(e.bits));
                    chk("pulse_cycle",   32'(cyc),      32'(e.at_cyc));
                end
                nsh  = 0;
                bits = '0;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W-1:0] last_dout = '0;
    bit           last_mm   = 1'b0;

    // Single load, called on a negedge while idle. Accepting edge E0 is the
    // next posedge; done is visible at the negedge with cyc == E0+5.
    task automatic do_load(input logic [W-1:0] w, input bit force_mm);
        int n;
        n     = cyc;
        start = 1'b1;
        word  = w;
        push_exp(1'b0, force_mm ? 4'b0000 : w, force_mm, W, {4'b0000, w}, n + 6);
        neg(1);
        start = 1'b0;
        word  = 4'b0000;             // capture already happened
        chk("mismatch_cleared_on_accept", 32'(mismatch), 0);
        chk("ready_low_after_accept", 32'(ready), 0);
        if (force_mm) begin
            neg(4);                  // CHECK cycle
            force_zero = 1'b1;
            neg(1);
            force_zero = 1'b0;
            chk("mismatch_set", 32'(mismatch), 1);
            neg(1);
        end else begin
            neg(6);
        end
        chk("ready_back", 32'(ready), 1);
        last_dout = force_mm ? 4'b0000 : w;
        last_mm   = force_mm;
        neg(1);
    endtask

    initial begin
        int n;

        // Reset held with start asserted.
        rst_n = 1'b0;
        start = 1'b1;
        word  = 4'b1010;
        neg(3);
        chk("rst_ready",     32'(ready), 1);
        chk("rst_sr_enable", 32'(sr_enable), 0);
        chk("rst_sr_din",    32'(sr_din), 0);
        chk("rst_done",      32'(done), 0);
        chk("rst_aborted",   32'(aborted), 0);
        chk("rst_data_out",  32'(data_out), 0);
        chk("rst_mismatch",  32'(mismatch), 0);
        start = 1'b0;
        rst_n = 1'b1;
        neg(3);
        chk("post_rst_ready", 32'(ready), 1);

        // Basic load.
        do_load(4'b1011, 1'b0);

        // Busy rejection: start with 1111 during SHIFT must be ignored.
        n     = cyc;
        start = 1'b1;
        word  = 4'b0110;
        push_exp(1'b0, 4'b0110, 1'b0, W, 8'b0000_0110, n + 6);
        neg(1);
        start = 1'b0;
        neg(1);
        start = 1'b1;
        word  = 4'b1111;
        neg(1);
        start = 1'b0;
        word  = 4'b0000;
        neg(6);
        last_dout = 4'b0110;
        last_mm   = 1'b0;

        // Back-to-back with start held high; second load accepted 7 cycles later.
        n     = cyc;
        start = 1'b1;
        word  = 4'b1001;
        push_exp(1'b0, 4'b1001, 1'b0, W, 8'b0000_1001, n + 6);
        push_exp(1'b0, 4'b0011, 1'b0, W, 8'b0000_0011, n + 13);
        neg(1);
        word  = 4'b0011;
        neg(7);
        start = 1'b0;
        chk("b2b_second_accepted", 32'(ready), 0);
        neg(7);
        chk("b2b_ready_back", 32'(ready), 1);
        last_dout = 4'b0011;
        last_mm   = 1'b0;
        neg(1);

        // Abort in SHIFT cycle 1: two shifts (1,1), aborted pulse, outputs held.
        n     = cyc;
        start = 1'b1;
        word  = 4'b1110;
        push_exp(1'b1, last_dout, last_mm, 2, 8'b0000_0011, n + 3);
        neg(1);
        start = 1'b0;
        neg(1);
        abort = 1'b1;
        neg(1);
        abort = 1'b0;
        chk("abort_ready_low", 32'(ready), 0);
        neg(1);
        chk("abort_ready_back", 32'(ready), 1);
        neg(2);

        // Forced read-back error, then a clean load clears mismatch.
        do_load(4'b0101, 1'b1);
        do_load(4'b0011, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        start = 1'b1;
        word  = 4'b1100;
        neg(1);
        start = 1'b0;
        neg(1);
        chk("pre_rst_sr_enable", 32'(sr_enable), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sr_enable", 32'(sr_enable), 0);
        chk("async_rst_sr_din",    32'(sr_din), 0);
        chk("async_rst_ready",     32'(ready), 1);
        chk("async_rst_data_out",  32'(data_out), 0);
        neg(2);
        #2 rst_n = 1'b1;
        neg(8);
        last_dout = 4'b0000;
        last_mm   = 1'b0;

        // Recovery after reset.
        do_load(4'b0111, 1'b0);

        neg(5);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
